// File: rtl/wb_axi_pkg.sv
`default_nettype none
// ============================================================================
// Package     : wb_axi_pkg
// Description : Shared types, constants and helpers for the Wishbone
//               round-robin arbiter placed in front of the AXI bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_axi_pkg;

  // Arbiter control states
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  // Largest supported master count; grant indices are sized for it
  localparam int MAX_MASTERS = 8;
  localparam int GRANT_IDX_W = $clog2(MAX_MASTERS);

  // Convert a one-hot vector to its bit index (0 when the vector is empty)
  function automatic logic [GRANT_IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [GRANT_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) begin
        idx = idx | GRANT_IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_encoder
// Description : Combinational round-robin priority encoder. Picks the first
//               set request strictly after i_last_idx, wrapping around, so
//               the previous owner ends up with the lowest priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_encoder #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last_idx,
  output logic [N-1:0]     o_gnt,
  output logic             o_valid
);

  logic [N-1:0]   w_mask;
  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_iso;

  // Mask keeps only positions above the last owner
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign w_mask[gi] = (i_last_idx < IDX_W'(gi));
  end

  // Lower half: requests after the last owner; upper half: the wrapped search.
  // Isolating the lowest set bit of the doubled vector yields the winner.
  assign w_dbl   = {i_req, i_req & w_mask};
  assign w_iso   = w_dbl & ((~w_dbl) + (2*N)'(1));
  assign o_gnt   = w_iso[N-1:0] | w_iso[2*N-1:N];
  assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/wb_axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_axi_rr_arbiter
// Description : Round-robin arbiter sharing one Wishbone slave port (the
//               wb_to_axi_adapter) between NUM_MASTERS Wishbone masters.
//               Grant is held for a whole Wishbone cycle; a per-grant
//               watchdog aborts stalled transfers with an error.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_axi_rr_arbiter
  import wb_axi_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_wb_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wb_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_wb_sel_i,
  input  logic [NUM_MASTERS-1:0]            m_wb_we_i,
  input  logic [NUM_MASTERS-1:0]            m_wb_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_wb_cyc_i,
  output logic [DATA_WIDTH-1:0]             m_wb_dat_o,
  output logic [NUM_MASTERS-1:0]            m_wb_ack_o,
  output logic [NUM_MASTERS-1:0]            m_wb_err_o,
  output logic [ADDR_WIDTH-1:0]             s_wb_adr_o,
  output logic [DATA_WIDTH-1:0]             s_wb_dat_o,
  output logic [SEL_WIDTH-1:0]              s_wb_sel_o,
  output logic                              s_wb_we_o,
  output logic                              s_wb_stb_o,
  output logic                              s_wb_cyc_o,
  input  logic [DATA_WIDTH-1:0]             s_wb_dat_i,
  input  logic                              s_wb_ack_i,
  input  logic                              s_wb_err_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  // Watchdog width; minimum of one bit when the watchdog is disabled
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t r_state;
  arb_state_t w_next_state;

  logic [NUM_MASTERS-1:0] w_req;
  logic [NUM_MASTERS-1:0] w_arb_gnt;
  logic                   w_arb_valid;
  logic [GRANT_IDX_W-1:0] w_arb_idx;

  logic [NUM_MASTERS-1:0] r_grant_oh;
  logic [GRANT_IDX_W-1:0] r_grant_idx;
  logic [GRANT_IDX_W-1:0] r_last_idx;
  logic [WD_W-1:0]        r_wd;

  logic [ADDR_WIDTH-1:0]  w_sel_adr;
  logic [DATA_WIDTH-1:0]  w_sel_dat;
  logic [SEL_WIDTH-1:0]   w_sel_sel;
  logic                   w_sel_we;
  logic                   w_sel_stb;
  logic                   w_sel_cyc;

  logic                   w_busy;
  logic                   w_abort;
  logic                   w_stall;
  logic                   w_timeout;

  assign w_req   = m_wb_cyc_i & m_wb_stb_i;
  assign w_busy  = (r_state == BUSY);
  assign w_abort = (r_state == ABORT);

  rr_priority_encoder #(
    .N     (NUM_MASTERS),
    .IDX_W (GRANT_IDX_W)
  ) u_prio (
    .i_req      (w_req),
    .i_last_idx (r_last_idx),
    .o_gnt      (w_arb_gnt),
    .o_valid    (w_arb_valid)
  );

  assign w_arb_idx = onehot_to_idx(MAX_MASTERS'(w_arb_gnt));

  // Select the granted master's request fields (AND-OR mux on the one-hot grant)
  always_comb begin
    w_sel_adr = '0;
    w_sel_dat = '0;
    w_sel_sel = '0;
    w_sel_we  = 1'b0;
    w_sel_stb = 1'b0;
    w_sel_cyc = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_grant_oh[i]) begin
        w_sel_adr = m_wb_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_dat = m_wb_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_sel = m_wb_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
        w_sel_we  = m_wb_we_i[i];
        w_sel_stb = m_wb_stb_i[i];
        w_sel_cyc = m_wb_cyc_i[i];
      end
    end
  end

  // A stalled cycle: strobe out, no response from the adapter
  assign w_stall = w_busy & w_sel_cyc & w_sel_stb & ~s_wb_ack_i & ~s_wb_err_i;

  if (TIMEOUT_CYCLES > 0) begin : g_wd_on
    // Fires on the stalled cycle that brings the count up to the limit
    assign w_timeout = w_stall & (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
  end else begin : g_wd_off
    assign w_timeout = 1'b0;
  end

  // Next-state decision; release by the owner takes precedence over timeout
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB: begin
        if (w_arb_valid) begin
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        if (!w_sel_cyc) begin
          w_next_state = ARB;
        end else if (w_timeout) begin
          w_next_state = ABORT;
        end
      end
      ABORT: begin
        w_next_state = ARB;
      end
      default: begin
        w_next_state = ARB;
      end
    endcase
  end

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ARB;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Grant ownership and round-robin history
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_grant_oh  <= '0;
      r_grant_idx <= '0;
      r_last_idx  <= GRANT_IDX_W'(NUM_MASTERS - 1);
    end else begin
      case (r_state)
        ARB: begin
          if (w_arb_valid) begin
            r_grant_oh  <= w_arb_gnt;
            r_grant_idx <= w_arb_idx;
          end
        end
        BUSY: begin
          if (!w_sel_cyc) begin
            r_grant_oh <= '0;
            r_last_idx <= r_grant_idx;
          end
        end
        ABORT: begin
          r_grant_oh <= '0;
          r_last_idx <= r_grant_idx;
        end
        default: begin
          r_grant_oh <= '0;
        end
      endcase
    end
  end

  // Watchdog: counts stalled cycles, cleared by any response or state change
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_wd <= '0;
    end else if ((w_next_state != r_state) || s_wb_ack_i || s_wb_err_i) begin
      r_wd <= '0;
    end else if (w_stall) begin
      r_wd <= r_wd + WD_W'(1);
    end
  end

  // Slave-side outputs are live only while a grant is in BUSY
  assign s_wb_adr_o = w_busy ? w_sel_adr : '0;
  assign s_wb_dat_o = w_busy ? w_sel_dat : '0;
  assign s_wb_sel_o = w_busy ? w_sel_sel : '0;
  assign s_wb_we_o  = w_busy & w_sel_we;
  assign s_wb_stb_o = w_busy & w_sel_stb;
  assign s_wb_cyc_o = w_busy & w_sel_cyc;

  // Responses steered to the owner only; abort injects a one-cycle error
  assign m_wb_ack_o = {NUM_MASTERS{w_busy & w_sel_cyc & s_wb_ack_i}} & r_grant_oh;
  assign m_wb_err_o = ({NUM_MASTERS{w_busy & w_sel_cyc & s_wb_err_i}} |
                       {NUM_MASTERS{w_abort}}) & r_grant_oh;
  assign m_wb_dat_o = w_busy ? s_wb_dat_i : '0;
  assign grant_o    = r_grant_oh;

endmodule
`default_nettype wire
